// File: rtl/channel_tx_sequencer.sv
// Serves trigger-status / channel-dump requests and streams the bytes into the UART TX path.
// Optional CHANNEL_TX_HEADER_EN: prefix each channel dump with a 0xA1/0xA2 header byte.
module channel_tx_sequencer #(
    parameter int RAM_ADDR_WIDTH = 8,
    parameter int SAMPLE_WIDTH   = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_rqst_ch1,
    input  logic                      i_rqst_ch2,
    input  logic                      i_rqst_trigger_status,
    input  logic [SAMPLE_WIDTH-1:0]   i_trigger_status,
    input  logic [RAM_ADDR_WIDTH-1:0] i_buf_start_addr,
    output logic                      o_ram_rd_en,
    output logic [RAM_ADDR_WIDTH-1:0] o_ram_rd_addr,
    input  logic [SAMPLE_WIDTH-1:0]   i_ram_ch1_data,
    input  logic [SAMPLE_WIDTH-1:0]   i_ram_ch2_data,
    output logic [SAMPLE_WIDTH-1:0]   o_tx_data,
    output logic                      o_tx_valid,
    input  logic                      i_tx_ready,
    output logic                      o_busy
);

    localparam logic [RAM_ADDR_WIDTH:0] LAST_CNT = (RAM_ADDR_WIDTH+1)'((2**RAM_ADDR_WIDTH) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STATUS,
`ifdef CHANNEL_TX_HEADER_EN
        S_HEADER,
`endif
        S_READ,
        S_WAIT,
        S_SEND
    } state_t;

    state_t                    r_state;
    logic                      r_pend_trig, r_pend_ch1, r_pend_ch2;
    logic                      r_sel_ch2;
    logic [RAM_ADDR_WIDTH-1:0] r_addr;
    logic [RAM_ADDR_WIDTH:0]   r_count;

    logic w_start_trig, w_start_ch, w_clr_ch1, w_clr_ch2;
    logic [RAM_ADDR_WIDTH-1:0] w_addr_nxt;

    // Service start decisions; a pulse in the same cycle re-arms the flag.
    assign w_start_trig = (r_state == S_IDLE) && r_pend_trig;
    assign w_start_ch   = (r_state == S_IDLE) && !r_pend_trig && (r_pend_ch1 || r_pend_ch2);
    assign w_clr_ch1    = w_start_ch && r_pend_ch1;
    assign w_clr_ch2    = w_start_ch && !r_pend_ch1;
    assign w_addr_nxt   = r_addr + RAM_ADDR_WIDTH'(1);

    assign o_busy = (r_state != S_IDLE) || r_pend_trig || r_pend_ch1 || r_pend_ch2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_pend_trig   <= 1'b0;
            r_pend_ch1    <= 1'b0;
            r_pend_ch2    <= 1'b0;
            r_sel_ch2     <= 1'b0;
            r_addr        <= '0;
            r_count       <= '0;
            o_ram_rd_en   <= 1'b0;
            o_ram_rd_addr <= '0;
            o_tx_data     <= '0;
            o_tx_valid    <= 1'b0;
        end else begin
            r_pend_trig <= (r_pend_trig && !w_start_trig) || i_rqst_trigger_status;
            r_pend_ch1  <= (r_pend_ch1 && !w_clr_ch1) || i_rqst_ch1;
            r_pend_ch2  <= (r_pend_ch2 && !w_clr_ch2) || i_rqst_ch2;

            case (r_state)
                S_IDLE: begin
                    if (w_start_trig) begin
                        o_tx_data  <= i_trigger_status;
                        o_tx_valid <= 1'b1;
                        r_state    <= S_STATUS;
                    end else if (w_start_ch) begin
                        r_sel_ch2 <= !r_pend_ch1;
                        r_addr    <= i_buf_start_addr;
                        r_count   <= '0;
`ifdef CHANNEL_TX_HEADER_EN
                        o_tx_data  <= r_pend_ch1 ? SAMPLE_WIDTH'(8'hA1) : SAMPLE_WIDTH'(8'hA2);
                        o_tx_valid <= 1'b1;
                        r_state    <= S_HEADER;
`else
                        o_ram_rd_en   <= 1'b1;
                        o_ram_rd_addr <= i_buf_start_addr;
                        r_state       <= S_READ;
`endif
                    end
                end
                S_STATUS: begin
                    if (i_tx_ready) begin
                        o_tx_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
`ifdef CHANNEL_TX_HEADER_EN
                S_HEADER: begin
                    if (i_tx_ready) begin
                        o_tx_valid    <= 1'b0;
                        o_ram_rd_en   <= 1'b1;
                        o_ram_rd_addr <= r_addr;
                        r_state       <= S_READ;
                    end
                end
`endif
                S_READ: begin
                    o_ram_rd_en <= 1'b0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    o_tx_data  <= r_sel_ch2 ? i_ram_ch2_data : i_ram_ch1_data;
                    o_tx_valid <= 1'b1;
                    r_state    <= S_SEND;
                end
                S_SEND: begin
                    if (i_tx_ready) begin
                        o_tx_valid <= 1'b0;
                        if (r_count < LAST_CNT) begin
                            r_count       <= r_count + (RAM_ADDR_WIDTH+1)'(1);
                            r_addr        <= w_addr_nxt;
                            o_ram_rd_en   <= 1'b1;
                            o_ram_rd_addr <= w_addr_nxt;
                            r_state       <= S_READ;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/channel_tx_sequencer.md
# channel_tx_sequencer

- Serves the request pulses produced by the PC request decoder: `rqst_ch1`, `rqst_ch2` and `rqst_trigger_status`.
- For each request it streams either the trigger-status byte or a full dump of one channel's circular sample RAM into the UART TX byte path, using a valid/ready handshake.
- Sits between the request decoder and the TX FIFO/UART, and is the only reader of the sample RAM read ports.

## Interface
- `RAM_ADDR_WIDTH`, 8: sample RAM address width; depth and dump length are 2**RAM_ADDR_WIDTH.
- `SAMPLE_WIDTH`, 8: sample and TX byte width.
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `rqst_ch1` in 1: one-cycle pulse requesting a CH1 dump.
- `rqst_ch2` in 1: one-cycle pulse requesting a CH2 dump.
- `rqst_trigger_status` in 1: one-cycle pulse requesting a status byte.
- `trigger_status` in SAMPLE_WIDTH: status byte, sampled when it is loaded into `tx_data`.
- `buf_start_addr` in RAM_ADDR_WIDTH: address of the oldest sample, sampled when a dump starts.
- `ram_rd_en` out 1: RAM read strobe (registered).
- `ram_rd_addr` out RAM_ADDR_WIDTH: RAM read address (registered).
- `ram_ch1_data` in SAMPLE_WIDTH: CH1 RAM read data, valid 1 cycle after `ram_rd_en`.
- `ram_ch2_data` in SAMPLE_WIDTH: CH2 RAM read data, same latency.
- `tx_data` out SAMPLE_WIDTH: byte to the TX path.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: TX path accepts the byte.
- `busy` out 1: asserted when state≠IDLE or any pending flag is set.

## Operation
- **Pending flags:** `pend_trig`, `pend_ch1` and `pend_ch2` are each set by their pulse.
  - A flag is cleared at the edge where its service starts (IDLE exit).
  - A pulse arriving while the same item is in service sets the flag again, so the item is served once more afterwards.
  - Repeated pulses before service merge into one.
- **Service priority from IDLE:** TRIG > CH1 > CH2. Simultaneous pulses are all latched and served in that order, back-to-back.
- **FSM states:** IDLE, STATUS, HEADER, READ, WAIT, SEND.
- **IDLE:**
  - With `pend_trig`: load `tx_data` = `trigger_status`, go to STATUS.
  - With `pend_ch1` or `pend_ch2`: latch the channel select, load `addr` = `buf_start_addr`, clear `count`, then go to HEADER (macro defined) or READ.
- **STATUS / HEADER / SEND:** hold `tx_valid` high with stable `tx_data` until `tx_ready`. On handshake:
  - STATUS → IDLE.
  - HEADER → READ.
  - SEND → READ if `count` < 2**RAM_ADDR_WIDTH−1 (then `count`++, `addr`++), else IDLE.
- **READ:** `ram_rd_en`=1, `ram_rd_addr`=`addr` for one cycle; → WAIT.
- **WAIT:** load `tx_data` from the selected channel's RAM data; → SEND.
- **Address arithmetic:** `addr` is RAM_ADDR_WIDTH bits and wraps modulo depth (0xFF+1 → 0x00). `count` is RAM_ADDR_WIDTH+1 bits.
- **Byte count:** a dump sends exactly 2**RAM_ADDR_WIDTH samples, oldest first, plus the header if enabled.
- **`buf_start_addr` changes mid-dump** are ignored.
- **Reset:** `rst` at any time, including mid-dump, returns the FSM to IDLE and clears all flags, `count` and `addr`. Partial dumps are not resumed.

## Timing
- **Reset values:** `tx_valid`=0, `tx_data`=0, `ram_rd_en`=0, `ram_rd_addr`=0, `busy`=0.
- **Request latency:** the pulse is in cycle 0; `pend_*` is set at the end of cycle 0.
  - Status byte or header: `tx_valid` high in cycle 2.
  - First sample without header: `ram_rd_en` in cycle 2, `tx_valid` in cycle 4.
- **Per-sample cost:** 3 cycles minimum (READ, WAIT, SEND with `tx_ready`=1). `tx_valid` is low during READ and WAIT.
- **Handshake:** transfer occurs at a rising edge with `tx_valid`&`tx_ready`. `tx_ready` high while `tx_valid` is low has no effect.
- **Back-to-back services:** the next service's first byte appears 2 cycles after the last handshake of the previous one (through IDLE).

## Configuration
- **`CHANNEL_TX_HEADER_EN`**
  - Defined: each channel dump is prefixed by one header byte, 0xA1 (CH1) or 0xA2 (CH2), and a dump is 2**RAM_ADDR_WIDTH+1 bytes.
  - Undefined: HEADER state is absent; IDLE goes directly to READ and a dump is raw samples only.
  - The status byte never has a header.

## Test plan
- **CH1 dump with wrap:** `buf_start_addr`=0xFE, RAM CH1[i]=i, `rqst_ch1` pulse, `tx_ready`=1 → bytes [0xA1 if header] 0xFE, 0xFF, 0x00, 0x01, …, 0xFD; 256 samples; `busy` falls afterward.
- **Simultaneous requests:** all three pulses in one cycle with `trigger_status`=0x5A → 0x5A, then the full CH1 dump, then the full CH2 dump, with no idle gap beyond 2 cycles between services.
- **Backpressure:** `tx_ready` low for 10 cycles while `tx_valid`=1 → `tx_data` stable and no RAM read issued; the byte transfers on the first cycle with `tx_ready`=1.
- **Re-request during dump:** `rqst_ch2` pulsed at sample 100 of a CH2 dump → current dump completes, then a second full CH2 dump follows; an extra pulse before service does not produce a third dump.
- **Reset mid-dump:** `rst` for 1 cycle at sample 37 → next cycle `tx_valid`=0, `busy`=0, no further bytes; a new `rqst_ch1` restarts from `buf_start_addr`.
- **Latency check:** `rqst_trigger_status` in cycle 0 → `tx_valid` first high in cycle 2; with the header macro undefined, `rqst_ch1` in cycle 0 → `ram_rd_en` in cycle 2 and `tx_valid` in cycle 4.
